// File: rtl/vram_pkg.sv
// Shared video-RAM definitions: arbiter state encoding and the bus widths
// common to the timing generator, character writer and arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 12;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } vram_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus between the video-RAM arbiter and its neighbours: timing enables,
// writer handshake, RAM port and the fetched-pixel output.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = vram_pkg::VRAM_ADDR_W,
  parameter int unsigned DATA_W = vram_pkg::VRAM_DATA_W
);

  logic              hden;
  logic              vden;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              overrun;

  modport slave (
    input  hden, vden, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata, pix_data, pix_valid, overrun
  );

  modport master (
    output hden, vden, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata, pix_data, pix_valid, overrun
  );

endinterface

// File: rtl/vram_scan_addr.sv
// Display scan address: advances on each active cycle, wraps at DEPTH and
// restarts at 0 on the cycle after vden falls.
module vram_scan_addr import vram_pkg::*; #(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DEPTH  = 3072
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  input  logic              i_vden,
  output logic [ADDR_W-1:0] o_scan_addr
);

  logic              r_vden_d;
  logic [ADDR_W-1:0] r_scan_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vden_d    <= 1'b0;
      r_scan_addr <= '0;
    end else begin
      r_vden_d <= i_vden;
      if (r_vden_d && !i_vden) begin
        r_scan_addr <= '0;
      end else if (i_adv) begin
        r_scan_addr <= (r_scan_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_scan_addr + 1'b1;
      end
    end
  end

  assign o_scan_addr = r_scan_addr;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: display scan has absolute priority, writer
// requests are served one cycle each during blanking.
module vram_arbiter import vram_pkg::*; #(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned DATA_W   = VRAM_DATA_W,
  parameter int unsigned DEPTH    = 3072,
  parameter int unsigned MAX_WAIT = 1024
) (
  input  logic          vgaclk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  vram_state_e       r_state;
  vram_state_e       w_next;
  logic              w_active;
  logic              w_waiting;
  logic [ADDR_W-1:0] w_scan_addr;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              r_mem_we;
  logic              w_mem_we;
  logic              r_wr_ack;
  logic              w_wr_ack;

  logic              r_rd_pend;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_overrun;

  assign w_active = bus.hden & bus.vden;

  vram_scan_addr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_scan (
    .i_clk       (vgaclk),
    .i_rst       (reset),
    .i_adv       (w_active),
    .i_vden      (bus.vden),
    .o_scan_addr (w_scan_addr)
  );

  always_ff @(posedge vgaclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // r_wr_ack masks the still-high request in the cycle after its commit
  always_comb begin
    w_next = ST_IDLE;
    if (w_active)                       w_next = ST_SCAN;
    else if (bus.wr_req && !r_wr_ack)   w_next = ST_WRITE;
  end

  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_we    = 1'b0;
    w_wr_ack    = 1'b0;
    case (w_next)
      ST_SCAN: begin
        w_mem_addr = w_scan_addr;
      end
      ST_WRITE: begin
        w_mem_addr  = bus.wr_addr;
        w_mem_wdata = bus.wr_data;
        w_mem_we    = 1'b1;
        w_wr_ack    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_waiting = bus.wr_req && !r_wr_ack && (w_next != ST_WRITE);

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_wait_cnt  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
      r_wr_ack    <= w_wr_ack;
      // RAM data for a scan address arrives one cycle after it is presented
      r_rd_pend   <= (r_state == ST_SCAN);
      r_pix_valid <= r_rd_pend;
      if (r_rd_pend) r_pix_data <= bus.mem_rdata;
      if (w_next == ST_WRITE) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && (r_wait_cnt != CNT_W'(MAX_WAIT))) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_waiting && (r_wait_cnt >= CNT_W'(MAX_WAIT - 1))) r_overrun <= 1'b1;
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_valid = r_pix_valid;
  assign bus.overrun   = r_overrun;

endmodule
